// File: rtl/cu_pkg.sv
// Shared definitions for the serial-programmed control unit and its
// sequencer: instruction-frame opcodes, ALU select encodings, the
// sequencer state type and the default frame length.
package cu_pkg;

  localparam int FRAME_W_DEF = 8;

  // opcode field, frame bits [7:6]
  localparam logic [1:0] OP_INITLZ_MEM = 2'b00;
  localparam logic [1:0] OP_ARITH      = 2'b01;
  localparam logic [1:0] OP_LOGIC      = 2'b10;
  localparam logic [1:0] OP_BUFFER     = 2'b11;

  // ALU select; meaning depends on OP_ARITH vs OP_LOGIC
  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_AND = 1'b0;
  localparam logic SEL_SUB = 1'b1;
  localparam logic SEL_OR  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_RUN    = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/scan_shifter.sv
// Parallel-load PISO (tx) paired with a SIPO (rx) for the control unit's
// scan chain.
//   clk, reset : clock, synchronous active-high reset
//   load       : tx <= frame, rx <= 0
//   shift      : tx shifts left (MSB out first), rx shifts in ser_in at LSB
//   frame      : parallel frame to transmit
//   ser_in     : serial data returned by the control unit
//   ser_out    : current tx MSB
//   rx         : captured serial bits
module scan_shifter #(
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic [FRAME_W-1:0] frame,
  input  logic               ser_in,
  output logic               ser_out,
  output logic [FRAME_W-1:0] rx
);

  logic [FRAME_W-1:0] tx;

  // tx fills with zeros as it shifts, so after a full frame its MSB is 0;
  // ser_out is therefore only ever non-zero while a shift phase is active.
  assign ser_out = tx[FRAME_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      tx <= '0;
      rx <= '0;
    end else if (load) begin
      tx <= frame;
      rx <= '0;
    end else if (shift) begin
      tx <= {tx[FRAME_W-2:0], 1'b0};
      rx <= {rx[FRAME_W-2:0], ser_in};
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Sequencer for the serial-programmed control unit. Serialises a host frame
// MSB-first, then strobes update and run, captures the returned bits and
// pulses done. Also issues a clear strobe on request.
//   clk, reset  : clock, synchronous active-high reset
//   start/clear : host requests, sampled only in IDLE (clear wins)
//   frame       : instruction frame, latched on accepted start
//   busy, done  : status; done is a one-cycle pulse
//   result      : bits captured during the last frame's shift phase
//   ser_out/in  : serial data to / from the control unit
//   cu_reset, cu_shift, cu_update, cu_run : mutually exclusive strobes
//
// state  | meaning
// IDLE   | waiting for start/clear
// CLR    | cu_reset held for CLR_CYCLES
// SHIFT  | cu_shift held for FRAME_W cycles, frame serialised
// UPDATE | cu_update for one cycle
// RUN    | cu_run held for RUN_CYCLES
// DONE   | done pulse, result valid
module scan_sequencer
  import cu_pkg::*;
#(
  parameter int FRAME_W    = FRAME_W_DEF,
  parameter int RUN_CYCLES = 1,
  parameter int CLR_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               clear,
  input  logic [FRAME_W-1:0] frame,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] result,
  output logic               ser_out,
  input  logic               ser_in,
  output logic               cu_reset,
  output logic               cu_shift,
  output logic               cu_update,
  output logic               cu_run
);

  localparam int CNT_W = $clog2(max3(FRAME_W, RUN_CYCLES, CLR_CYCLES) + 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_CYCLES - 1);

  seq_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [FRAME_W-1:0] rx;
  logic               load, shift;

  assign load  = (state == ST_IDLE) && start && !clear;
  assign shift = (state == ST_SHIFT);

  scan_shifter #(.FRAME_W(FRAME_W)) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .shift   (shift),
    .frame   (frame),
    .ser_in  (ser_in),
    .ser_out (ser_out),
    .rx      (rx)
  );

  // Counter restarts at 0 on every state change, so it never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (clear)      state_nxt = ST_CLR;
        else if (start) state_nxt = ST_SHIFT;
      end
      ST_CLR: begin
        if (cnt == CLR_LAST) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
        end
      end
      ST_SHIFT: begin
        if (cnt == SHIFT_LAST) begin
          state_nxt = ST_UPDATE;
          cnt_nxt   = '0;
        end
      end
      ST_UPDATE: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
      ST_RUN: begin
        if (cnt == RUN_LAST) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode the next state, so they are registered and line up with
  // the state they describe. One-hot decode keeps the strobes exclusive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      cu_reset  <= 1'b0;
      cu_shift  <= 1'b0;
      cu_update <= 1'b0;
      cu_run    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_DONE);
      cu_reset  <= (state_nxt == ST_CLR);
      cu_shift  <= (state_nxt == ST_SHIFT);
      cu_update <= (state_nxt == ST_UPDATE);
      cu_run    <= (state_nxt == ST_RUN);
      // only a frame transaction (RUN -> DONE) refreshes result; clear keeps it
      if (state == ST_RUN && state_nxt == ST_DONE)
        result <= rx;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed self-checking bench for scan_sequencer (RUN_CYCLES=1, CLR_CYCLES=2).
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, clear, ser_in;
  logic [7:0] frame;
  logic       busy, done, ser_out;
  logic [7:0] result;
  logic       cu_reset, cu_shift, cu_update, cu_run;

  int checks = 0;
  int errors = 0;

  scan_sequencer #(.FRAME_W(8), .RUN_CYCLES(1), .CLR_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .clear     (clear),
    .frame     (frame),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .ser_out   (ser_out),
    .ser_in    (ser_in),
    .cu_reset  (cu_reset),
    .cu_shift  (cu_shift),
    .cu_update (cu_update),
    .cu_run    (cu_run)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // strobes {reset,shift,update,run} packed for compact checking
  function automatic logic [3:0] strobes();
    return {cu_reset, cu_shift, cu_update, cu_run};
  endfunction

  task automatic chk_excl(input string tag);
    chk(tag, 32'($countones(strobes()) <= 1), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {19'd0, busy, done, result, ser_out, strobes()}, 32'd0);
  endtask

  initial begin
    logic [7:0] fr, pat;
    int         nshift;
    logic       seen_done;

    reset = 1'b1; start = 1'b0; clear = 1'b0; ser_in = 1'b0; frame = '0;
    repeat (3) tick();
    chk_all_zero("reset_outputs");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all_zero("idle_after_reset");
    end

    // frame transaction: INITLZ_MEM, addr 2, data B; loopback pattern A6
    fr  = 8'b00_10_1011;
    pat = 8'b1010_0110;
    frame = fr; start = 1'b1;
    tick();                                   // edge N: start accepted
    start = 1'b0;
    frame = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("shift_strobe_%0d", i), {28'd0, strobes()}, 32'b0100);
      chk($sformatf("ser_out_%0d", i), {31'd0, ser_out}, {31'd0, fr[7-i]});
      chk("busy_shift", {31'd0, busy}, 32'd1);
      ser_in = pat[7-i];
      start  = (i == 2);                      // re-pulse during SHIFT: ignored
      tick();
    end
    start = 1'b0; ser_in = 1'b0;
    chk("update_strobe", {28'd0, strobes()}, 32'b0010);
    chk("ser_out_after_shift", {31'd0, ser_out}, 32'd0);
    tick();
    chk("run_strobe", {28'd0, strobes()}, 32'b0001);
    chk("done_not_yet", {31'd0, done}, 32'd0);
    tick();                                   // N+11
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd1);
    chk("done_strobes", {28'd0, strobes()}, 32'd0);
    chk("result_a6", {24'd0, result}, 32'hA6);
    start = 1'b1;                             // start during DONE: ignored
    frame = 8'hFF;
    tick();
    start = 1'b0;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_dropped", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_strobes", {28'd0, strobes()}, 32'd0);
      chk("hold_result", {24'd0, result}, 32'hA6);
      chk("hold_busy", {31'd0, busy}, 32'd0);
      tick();
    end

    // clear and start together: clear wins, CLR_CYCLES=2
    frame = 8'h3C; start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    chk("clr_cycle1", {28'd0, strobes()}, 32'b1000);
    chk("clr_busy", {31'd0, busy}, 32'd1);
    chk("clr_ser_out", {31'd0, ser_out}, 32'd0);
    tick();
    chk("clr_cycle2", {28'd0, strobes()}, 32'b1000);
    chk("clr_no_done_yet", {31'd0, done}, 32'd0);
    tick();
    chk("clr_done", {31'd0, done}, 32'd1);
    chk("clr_strobes_off", {28'd0, strobes()}, 32'd0);
    chk("clr_result_kept", {24'd0, result}, 32'hA6);
    tick();
    chk("clr_idle", {30'd0, busy, done}, 32'd0);
    chk("clr_no_shift", {28'd0, strobes()}, 32'd0);

    // reset during the 4th shift cycle
    frame = 8'hC3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_shift_active", {31'd0, cu_shift}, 32'd1);
    reset = 1'b1;
    tick();
    chk_all_zero("abort_reset");
    reset = 1'b0;
    tick();
    chk_all_zero("abort_stays_idle");

    // fresh transaction after abort, ser_in held high
    fr = 8'h5A;
    frame = fr; start = 1'b1; ser_in = 1'b1;
    tick();
    start = 1'b0;
    nshift = 0; seen_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk_excl("exclusive");
      if (cu_shift) begin
        chk($sformatf("ser_out2_%0d", nshift), {31'd0, ser_out}, {31'd0, fr[7-nshift]});
        nshift++;
      end
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      tick();
    end
    chk("done_within_budget", {31'd0, seen_done}, 32'd1);
    chk("shift_count", nshift, 32'd8);
    chk("result_ff", {24'd0, result}, 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Sequencing FSM for the serial-programmed control unit (8-bit instruction frame: opcode[7:6], field[5:4], data/addr[3:0]).
- Accepts a parallel frame from a host. Serialises it MSB-first onto the control unit's data_in. Then issues update and run strobes.
- Captures the bits the control unit shifts out and reports a one-cycle done.
- Also drives the control unit's clear (reset) strobe on request.
- Guarantees cu_reset / cu_run / cu_shift / cu_update are mutually exclusive every cycle.

Parameters:
FRAME_W, 8, frame length in bits; number of shift cycles per transaction
RUN_CYCLES, 1, cycles cu_run is held high after update (>=1)
CLR_CYCLES, 1, cycles cu_reset is held high for a clear request (>=1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset of this block
start  input  1  host request: program frame; sampled only in IDLE
clear  input  1  host request: clear control unit; sampled only in IDLE
frame  input  FRAME_W  instruction frame, latched on accepted start
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle pulse at end of transaction or clear
result  output  FRAME_W  bits captured from ser_in during last shift phase
ser_out  output  1  serial data to control unit data_in
ser_in  input  1  serial data from control unit data_out
cu_reset  output  1  clear strobe to control unit
cu_shift  output  1  shift strobe to control unit
cu_update  output  1  update strobe to control unit
cu_run  output  1  run strobe to control unit

Behaviour:
- Reset (reset=1 at posedge): state IDLE, all outputs 0 (busy, done, result, ser_out, all cu_* strobes), internal tx/rx registers and counter 0. Reset mid-transaction aborts immediately; no further strobes.
- All outputs are registered; strobes are decoded from the next state and take effect the cycle after the transition decision.
- States: IDLE, CLR, SHIFT, UPDATE, RUN, DONE.
- IDLE
  - clear=1 -> CLR (clear wins if start also high; start is dropped).
  - else start=1 -> latch frame into tx, rx=0, cnt=0 -> SHIFT.
  - start/clear in any other state are ignored; they are not queued.
- CLR: cu_reset=1 for CLR_CYCLES cycles -> DONE. result is unchanged.
- SHIFT: cu_shift=1 for exactly FRAME_W cycles.
  - ser_out = tx[FRAME_W-1]; tx shifts left one bit per cycle. Bit 7 is presented first, bit 0 last.
  - At each posedge ending a shift cycle, rx = {rx[FRAME_W-2:0], ser_in}.
  - cnt counts 0..FRAME_W-1; at cnt=FRAME_W-1 -> UPDATE.
  - ser_out=0 whenever cu_shift=0.
- UPDATE: cu_update=1 for one cycle -> RUN.
- RUN: cu_run=1 for RUN_CYCLES cycles -> DONE.
- DONE:
  - done=1 for one cycle.
  - result is loaded from rx on entry for a frame transaction, so it is valid while done=1 and holds until the next frame transaction completes.
  - Then -> IDLE. A start arriving during DONE is ignored.
- Latency: start accepted at edge N gives the following.
  - cu_shift high in cycles N+1..N+8.
  - cu_update in N+9.
  - cu_run in N+10..N+9+RUN_CYCLES.
  - done in N+10+RUN_CYCLES.
  - Total busy = FRAME_W+RUN_CYCLES+2 cycles.
- Clear latency: clear at edge N gives cu_reset in N+1..N+CLR_CYCLES and done in N+CLR_CYCLES+1.
- Counter width: clog2 of max(FRAME_W, RUN_CYCLES, CLR_CYCLES)+1. There is no wrap: the counter resets on every state entry.

Decomposition:
- Shared package (cu_pkg):
  - opcode constants OP_INITLZ_MEM=2'b00, OP_ARITH=2'b01, OP_LOGIC=2'b10, OP_BUFFER=2'b11
  - ALU select constants SEL_ADD/SEL_AND=0, SEL_SUB/SEL_OR=1
  - the sequencer state enum
  - FRAME_W default
- One sub-module: scan_shifter.
  - Parallel-load PISO (tx) plus SIPO (rx) pair with load/shift enables, parameterised by FRAME_W.
  - The FSM and counter stay in scan_sequencer.

Test Plan:
- Reset held 3 cycles, then released: all outputs 0, busy=0; strobes stay 0 with start=clear=0.
- start with frame=8'b00_10_1011 (INITLZ_MEM, addr 2, data 4'hB), RUN_CYCLES=1: ser_out = 0,0,1,0,1,0,1,1 over 8 cu_shift cycles. Then cu_update 1 cycle, cu_run 1 cycle, done at N+11; at most one strobe high per cycle.
- ser_in loopback driven 1,0,1,0,0,1,1,0 during shift: result = 8'hA6 when done=1; result then holds through 5 idle cycles.
- start and clear asserted together in IDLE, CLR_CYCLES=2: cu_reset high 2 cycles, no cu_shift, done 1 cycle, result unchanged.
- start re-pulsed during SHIFT and during DONE: ignored. Exactly one transaction occurs and busy drops after one done.
- reset asserted at 4th shift cycle: next cycle all strobes 0, busy=0, result=0. A new start after release runs a full 8-cycle shift.
